approach_request_unit: RTL and testbench
========================================

Name: approach_request_unit

Overview:
- Request-side front end for the four-approach traffic light controller.
- Takes raw pushbutton/vehicle-sensor inputs for approaches A–D, then synchronizes and debounces them.
- Latches each request until the controller serves that approach, and drives the controller's request lines.
- Closes the loop by monitoring the controller's lamp outputs: clears served requests, flags starved approaches, and flags illegal lamp combinations.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before the debounced level changes (legal range ≥2).
- MAX_WAIT, 32: cycles a pending, unserved request may wait before its starve flag asserts (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  4  raw request inputs, bit0=A … bit3=D; asynchronous to clk.
- grn  input  4  green lamp state from controller, bit0=A … bit3=D.
- yel  input  4  yellow lamp state from controller.
- red  input  4  red lamp state from controller.
- req  output 4  request lines to controller (Pa..Pd), bit0=A.
- starve  output 4  per-approach wait-limit flag.
- lamp_err  output 1  sticky illegal-lamp-pattern flag.

Behaviour:
- Reset (async, rst=1): every register clears immediately. This covers the sync flops, debounce counters, debounced levels, pending bits, wait counters and lamp_err. req=0, starve=0, lamp_err=0. Reset mid-debounce or mid-wait discards all progress.
- Synchronizer: btn passes through a 2-flop synchronizer per bit, giving s[i].
- Debounce, per bit:
  - If s[i]==db[i], cnt[i]<=0.
  - Otherwise cnt[i] increments. When cnt[i]==DEBOUNCE_CYCLES-1 and s still differs, db[i]<=s[i] and cnt[i]<=0.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes db.
- Pending latch pend[i], registered:
  - Clear has priority: if grn[i]=1, pend[i]<=0.
  - Else if db[i] rose this cycle (db=1, previous db=0), pend[i]<=1.
  - Else pend[i] holds.
  - A rise that occurs while grn[i]=1 is not latched.
- Output: req[i] = pend[i] | (db[i] & grn[i]). This is combinational from registers plus grn. A button held during its own green therefore keeps req high, which extends that green in the controller.
- Latency: btn rises and stays high, first sampled at edge 1 → s at edge 2 → db at edge 2+DEBOUNCE_CYCLES → pend/req at edge 3+DEBOUNCE_CYCLES. With the default, req rises after edge 7.
- Wait counter wcnt[i], width clog2(MAX_WAIT+1):
  - Increments each cycle pend[i]=1 and grn[i]=0.
  - Saturates at MAX_WAIT, with no wrap.
  - Clears to 0 whenever pend[i]=0 or grn[i]=1.
  - starve[i] = (wcnt[i]==MAX_WAIT), registered.
- Lamp checker, registered each cycle. lamp_err<=1 if either:
  - any approach i has {red,yel,grn}[i] not exactly one-hot; or
  - more than one bit of (grn|yel) is set.
- lamp_err is sticky until rst. No other effect: requests keep operating.
- Simultaneous events:
  - Requests on multiple approaches latch independently; there is no arbitration here.
  - grn clear and db rise in the same cycle → pend=0.
- Combinational loop: no combinational path from req back to any input.

Test Plan:
- Reset: assert rst mid-operation with pend=4'b0101 and starve[0]=1 → req, starve and lamp_err all 0 immediately, before any clk edge; they stay 0 until new stimulus.
- Debounce: btn[1] high for 3 cycles then low; DEBOUNCE_CYCLES=4 → req stays 0. Then btn[1] held high → req[1]=1 exactly after edge 7 from first sample.
- Service clear: pend[2]=1, btn released, grn=4'b0100 for one cycle → req[2] drops the cycle after grn; a new btn[2] press during that green is not latched.
- Green extension: btn[0] held high, grn[0]=1 → req[0]=1 throughout; btn released and debounced → req[0]=0 while grn[0] stays 1.
- Starvation: pend[3]=1, grn[3]=0 for 32 cycles → starve[3]=1 on cycle 32. It stays 1 (saturated) through cycle 40, then clears the cycle after grn[3]=1.
- Lamp checker: legal patterns (grn=0001, red=1110) keep lamp_err=0. grn=0011 → lamp_err=1 next edge. Red+green on the same approach → lamp_err=1. lamp_err persists until rst.

Source files
------------

// File: rtl/approach_request_unit.sv
// Request-side front end for a four-approach traffic light controller.
// Synchronizes and debounces the raw request inputs and latches each request
// until its approach turns green. It also watches the lamp outputs for
// starvation and for illegal lamp patterns.
module approach_request_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_WAIT        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] grn,
  input  logic [3:0] yel,
  input  logic [3:0] red,
  output logic [3:0] req,
  output logic [3:0] starve,
  output logic       lamp_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  // Returns true when exactly one of the three lamps of an approach is lit.
  function automatic logic one_hot3(input logic [2:0] v);
    logic r;
    case (v)
      3'b001, 3'b010, 3'b100: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Returns true when more than one bit of a 4-bit vector is set.
  function automatic logic multi_hot4(input logic [3:0] v);
    return ((v & (v - 4'd1)) != 4'd0);
  endfunction

  logic [3:0]         sync_a_r, sync_b_r;
  logic [3:0][CW-1:0] cnt_r, cnt_s;
  logic [3:0]         db_r, db_s, db_prev_r;
  logic [3:0]         pend_r, pend_s;
  logic [3:0][WW-1:0] wcnt_r, wcnt_s;
  logic [3:0]         starve_r, starve_s;
  logic               lamp_err_r, lamp_bad_s;

  // Per-approach debounce, pending latch and wait-counter next-state logic.
  always_comb begin
    cnt_s    = cnt_r;
    db_s     = db_r;
    pend_s   = pend_r;
    wcnt_s   = wcnt_r;
    starve_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      // The debounced level only moves after DEBOUNCE_CYCLES disagreeing samples.
      if (sync_b_r[i] == db_r[i]) begin
        cnt_s[i] = {CW{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        cnt_s[i] = {CW{1'b0}};
        db_s[i]  = sync_b_r[i];
      end else begin
        cnt_s[i] = cnt_r[i] + CW'(1);
      end

      // Green service wins over a simultaneous new press.
      if (grn[i]) begin
        pend_s[i] = 1'b0;
      end else if (db_r[i] && !db_prev_r[i]) begin
        pend_s[i] = 1'b1;
      end else begin
        pend_s[i] = pend_r[i];
      end

      // The wait counter saturates rather than wrapping, so starve stays high.
      if (pend_r[i] && !grn[i]) begin
        if (wcnt_r[i] == WAIT_MAX) begin
          wcnt_s[i] = wcnt_r[i];
        end else begin
          wcnt_s[i] = wcnt_r[i] + WW'(1);
        end
      end else begin
        wcnt_s[i] = {WW{1'b0}};
      end
      starve_s[i] = (wcnt_s[i] == WAIT_MAX);
    end
  end

  // Detects an illegal lamp combination on the current lamp inputs.
  always_comb begin
    lamp_bad_s = multi_hot4(grn | yel);
    for (int i = 0; i < 4; i++) begin
      if (!one_hot3({red[i], yel[i], grn[i]})) begin
        lamp_bad_s = 1'b1;
      end else begin
        lamp_bad_s = lamp_bad_s;
      end
    end
  end

  // Holds the synchronizer, debounce, pending, wait and error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_r   <= 4'b0000;
      sync_b_r   <= 4'b0000;
      cnt_r      <= {4{ {CW{1'b0}} }};
      db_r       <= 4'b0000;
      db_prev_r  <= 4'b0000;
      pend_r     <= 4'b0000;
      wcnt_r     <= {4{ {WW{1'b0}} }};
      starve_r   <= 4'b0000;
      lamp_err_r <= 1'b0;
    end else begin
      sync_a_r   <= btn;
      sync_b_r   <= sync_a_r;
      cnt_r      <= cnt_s;
      db_r       <= db_s;
      db_prev_r  <= db_r;
      pend_r     <= pend_s;
      wcnt_r     <= wcnt_s;
      starve_r   <= starve_s;
      lamp_err_r <= lamp_err_r | lamp_bad_s;
    end
  end

  // A button held during its own green keeps the request up to extend the green.
  assign req      = pend_r | (db_r & grn);
  assign starve   = starve_r;
  assign lamp_err = lamp_err_r;

endmodule

// File: tb/tb_approach_request_unit.sv
// Directed, table-driven bench for approach_request_unit (default parameters).
module tb_approach_request_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn, grn, yel, red;
  logic [3:0] req, starve;
  logic       lamp_err;

  int compared = 0;
  int failed   = 0;

  approach_request_unit #(.DEBOUNCE_CYCLES(4), .MAX_WAIT(32)) dut (
    .clk(clk), .rst(rst), .btn(btn), .grn(grn), .yel(yel), .red(red),
    .req(req), .starve(starve), .lamp_err(lamp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] btn, grn, yel, red;
    logic [3:0] req, starve;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int n, input logic [3:0] b, input logic [3:0] g,
                              input logic [3:0] y, input logic [3:0] r,
                              input logic [3:0] q, input logic [3:0] s, input logic e);
    vec_t v;
    v.n = n; v.btn = b; v.grn = g; v.yel = y; v.red = r;
    v.req = q; v.starve = s; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] q, input logic [3:0] s,
                           input logic e);
    check({name, ".req"}, req, q);
    check({name, ".starve"}, starve, s);
    check({name, ".lamp_err"}, {3'b000, lamp_err}, {3'b000, e});
  endtask

  task automatic idle_inputs();
    btn = 4'h0; grn = 4'h0; yel = 4'h0; red = 4'hF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("reset_pulse", 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check_all("por", 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //                n  btn   grn   yel   red   req   starve err
    vecs.push_back(mk(2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0)); // idle
    vecs.push_back(mk(3, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0)); // 3-sample glitch
    vecs.push_back(mk(6, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0)); // glitch ignored
    vecs.push_back(mk(6, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0)); // edges 1..6
    vecs.push_back(mk(3, 4'h2, 4'h0, 4'h0, 4'hF, 4'h2, 4'h0, 1'b0)); // req after edge 7
    vecs.push_back(mk(8, 4'h0, 4'h0, 4'h0, 4'hF, 4'h2, 4'h0, 1'b0)); // latched after release
    vecs.push_back(mk(1, 4'h0, 4'h2, 4'h0, 4'hD, 4'h0, 4'h0, 1'b0)); // served by green
    vecs.push_back(mk(2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(5, 4'h4, 4'h4, 4'h0, 4'hB, 4'h0, 4'h0, 1'b0)); // press during green
    vecs.push_back(mk(3, 4'h4, 4'h4, 4'h0, 4'hB, 4'h4, 4'h0, 1'b0)); // green extension
    vecs.push_back(mk(5, 4'h0, 4'h4, 4'h0, 4'hB, 4'h4, 4'h0, 1'b0)); // release debouncing
    vecs.push_back(mk(2, 4'h0, 4'h4, 4'h0, 4'hB, 4'h0, 4'h0, 1'b0)); // drops, green stays
    vecs.push_back(mk(2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0)); // press was not latched
    vecs.push_back(mk(6, 4'h9, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0)); // A and D together
    vecs.push_back(mk(2, 4'h9, 4'h0, 4'h0, 4'hF, 4'h9, 4'h0, 1'b0));
    vecs.push_back(mk(6, 4'h0, 4'h0, 4'h0, 4'hF, 4'h9, 4'h0, 1'b0));
    vecs.push_back(mk(1, 4'h0, 4'h1, 4'h0, 4'hE, 4'h8, 4'h0, 1'b0)); // serve A only
    vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h8, 4'h0, 1'b0));
    vecs.push_back(mk(1, 4'h0, 4'h8, 4'h0, 4'h7, 4'h0, 4'h0, 1'b0)); // serve D
    vecs.push_back(mk(2, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0));

    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].n; r++) begin
        btn = vecs[k].btn; grn = vecs[k].grn; yel = vecs[k].yel; red = vecs[k].red;
        step();
        check_all($sformatf("row%0d.%0d", k, r), vecs[k].req, vecs[k].starve, vecs[k].err);
      end
    end

    // Starvation on D: pend rises at edge 7, starve after 32 waiting cycles (edge 39).
    for (int c = 1; c <= 45; c++) begin
      btn = (c <= 10) ? 4'h8 : 4'h0;
      step();
      check($sformatf("starve_req.c%0d", c), req, (c >= 7) ? 4'h8 : 4'h0);
      check($sformatf("starve_flag.c%0d", c), starve, (c >= 39) ? 4'h8 : 4'h0);
    end
    grn = 4'h8; red = 4'h7;
    step();
    check_all("starve_served", 4'h0, 4'h0, 1'b0);
    idle_inputs();
    step();
    check_all("starve_after", 4'h0, 4'h0, 1'b0);

    // Lamp checker: two greens at once.
    grn = 4'h3; red = 4'hC;
    step();
    check_all("lamp_two_green", 4'h0, 4'h0, 1'b1);
    idle_inputs();
    for (int r = 0; r < 3; r++) begin
      step();
      check_all($sformatf("lamp_sticky%0d", r), 4'h0, 4'h0, 1'b1);
    end
    do_reset();
    step();
    check_all("lamp_cleared", 4'h0, 4'h0, 1'b0);
    // Red and green on the same approach.
    grn = 4'h1; red = 4'hF;
    step();
    check_all("lamp_red_green", 4'h0, 4'h0, 1'b1);
    do_reset();
    // Green on A with yellow on B.
    grn = 4'h1; yel = 4'h2; red = 4'hC;
    step();
    check_all("lamp_grn_yel", 4'h0, 4'h0, 1'b1);
    do_reset();
    // Dark approach A.
    red = 4'hE;
    step();
    check_all("lamp_dark", 4'h0, 4'h0, 1'b1);
    idle_inputs();

    // Reset mid-operation: pend=0101, starve=0101, lamp_err=1.
    for (int c = 1; c <= 45; c++) begin
      btn = (c <= 8) ? 4'h5 : 4'h0;
      step();
    end
    check_all("pre_reset", 4'h5, 4'h5, 1'b1);
    btn = 4'h5;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("async_reset", 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    btn = 4'h0;
    for (int r = 0; r < 4; r++) begin
      step();
      check_all($sformatf("post_reset%0d", r), 4'h0, 4'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
